// File: rtl/nios2_rx_data_in.sv
// Avalon-MM input port: synchronizes in_port, detects per-bit edges into a sticky
// W1C capture register, and raises a level irq gated by a per-bit mask.
module nios2_rx_data_in #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic             rd_en, wr_en;
  logic             unused_wd;

  assign data_sync = sync_q[SYNC_STAGES-1];
  assign rd_en     = chipselect & ~read_n;
  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = &{1'b0, writedata};

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    if (EDGE_TYPE == 1) begin
      edge_det = data_sync & ~prev_q;
    end else if (EDGE_TYPE == 2) begin
      edge_det = ~data_sync & prev_q;
    end else begin
      edge_det = data_sync ^ prev_q;
    end
  end

  // A new edge wins over a same-cycle W1C of the same bit.
  always_comb begin
    clr_bits = '0;
    mask_d   = mask_q;
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    cap_d = edge_det | (cap_q & ~clr_bits);
  end

  // Reads return the pre-write register values; readdata holds otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        2'd0:    rdata_d = 32'(data_sync);
        2'd2:    rdata_d = 32'(mask_q);
        2'd3:    rdata_d = 32'(cap_q);
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= data_sync;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios2_rx_data_in.sv
// Bench for nios2_rx_data_in: three instances (any/rising/falling edge) share one bus and are
// checked every cycle against a history-based reference model through an expectation queue.
module tb_nios2_rx_data_in;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'd0;
  logic [31:0] rdata0, rdata1, rdata2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  nios2_rx_data_in #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata0),
    .in_port(in_port), .irq(irq0));
  nios2_rx_data_in #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata1),
    .in_port(in_port), .irq(irq1));
  nios2_rx_data_in #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata2),
    .in_port(in_port), .irq(irq2));

  typedef struct packed {
    logic [2:0][31:0] rd;
    logic [2:0]       irq;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: in_port history since reset, plus mask, capture and readdata per instance.
  logic [3:0]       hist[$];
  logic [3:0]       m_mask;
  logic [2:0][3:0]  m_cap;
  logic [2:0][31:0] m_rd;

  function automatic logic [3:0] synced_after(int n);
    return (n >= S) ? hist[n-S] : 4'h0;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endfunction

  task automatic cyc(input logic rst, input logic [3:0] inp, input logic cs, input logic rd,
                     input logic wr, input logic [1:0] addr, input logic [31:0] wd);
    logic [3:0] cur, old, w1c;
    logic [2:0][3:0] edg;
    exp_t e;
    @(negedge clk);
    #1;
    reset_n = ~rst; in_port = inp; chipselect = cs; read_n = ~rd; write_n = ~wr;
    address = addr; writedata = wd;
    if (rst) begin
      hist.delete();
      m_mask = '0; m_cap = '0; m_rd = '0;
      #1;
      chk("irq_any_in_reset", 32'(irq0), 32'd0);
      chk("irq_rise_in_reset", 32'(irq1), 32'd0);
      chk("irq_fall_in_reset", 32'(irq2), 32'd0);
      chk("rdata_any_in_reset", rdata0, 32'd0);
    end else begin
      cur = synced_after(hist.size());
      old = synced_after(hist.size() - 1);
      edg[0] = cur ^ old;
      edg[1] = cur & ~old;
      edg[2] = ~cur & old;
      for (int t = 0; t < 3; t++) begin
        if (cs && rd) begin
          case (addr)
            2'd0:    m_rd[t] = {28'd0, cur};
            2'd2:    m_rd[t] = {28'd0, m_mask};
            2'd3:    m_rd[t] = {28'd0, m_cap[t]};
            default: m_rd[t] = 32'd0;
          endcase
        end
      end
      w1c = (cs && wr && addr == 2'd3) ? wd[3:0] : 4'h0;
      if (cs && wr && addr == 2'd2) m_mask = wd[3:0];
      for (int t = 0; t < 3; t++) m_cap[t] = edg[t] | (m_cap[t] & ~w1c);
      hist.push_back(inp);
    end
    e.rd = m_rd;
    for (int t = 0; t < 3; t++) e.irq[t] = |(m_cap[t] & m_mask);
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] inp, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, inp, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd_reg(input logic [3:0] inp, input logic [1:0] addr);
    cyc(1'b0, inp, 1'b1, 1'b1, 1'b0, addr, 32'd0);
  endtask

  task automatic wr_reg(input logic [3:0] inp, input logic [1:0] addr, input logic [31:0] wd);
    cyc(1'b0, inp, 1'b1, 1'b0, 1'b1, addr, wd);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("readdata_any", rdata0, e.rd[0]);
      chk("readdata_rise", rdata1, e.rd[1]);
      chk("readdata_fall", rdata2, e.rd[2]);
      chk("irq_any", 32'(irq0), 32'(e.irq[0]));
      chk("irq_rise", 32'(irq1), 32'(e.irq[1]));
      chk("irq_fall", 32'(irq2), 32'(e.irq[2]));
    end
  end

  initial begin
    logic [3:0] pin;
    int r;
    m_mask = '0; m_cap = '0; m_rd = '0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);

    // Input 4'hA, readback of DATA and EDGECAP.
    idle(4'hA, 3);
    rd_reg(4'hA, 2'd0);
    rd_reg(4'hA, 2'd3);

    // Masked bit 1 toggles, then cleared by W1C.
    wr_reg(4'hA, 2'd3, 32'hF);
    wr_reg(4'hA, 2'd2, 32'h2);
    idle(4'h8, 4);
    idle(4'hA, 4);
    wr_reg(4'hA, 2'd3, 32'h2);
    idle(4'hA, 2);

    // Edge and W1C of bit 0 land on the same clock edge.
    wr_reg(4'hA, 2'd2, 32'h1);
    idle(4'hB, 4);
    wr_reg(4'hB, 2'd3, 32'h1);
    idle(4'hA, 2);
    wr_reg(4'hA, 2'd3, 32'h1);
    rd_reg(4'hA, 2'd3);

    // Pulse on bit 3 with 4-clock levels.
    wr_reg(4'hA, 2'd3, 32'hF);
    idle(4'h2, 6);
    wr_reg(4'h2, 2'd3, 32'hF);
    idle(4'hA, 4);
    idle(4'h2, 4);
    rd_reg(4'h2, 2'd3);

    // Mask write with all ones, reserved read, non-destructive capture read.
    wr_reg(4'h2, 2'd2, 32'hFFFF_FFFF);
    rd_reg(4'h2, 2'd2);
    rd_reg(4'h2, 2'd1);
    rd_reg(4'h2, 2'd3);
    rd_reg(4'h2, 2'd3);
    cyc(1'b0, 4'h2, 1'b1, 1'b1, 1'b1, 2'd2, 32'h5);

    // Full capture and mask, then reset in the middle of a read.
    wr_reg(4'h2, 2'd2, 32'hF);
    idle(4'hD, 3);
    idle(4'h2, 3);
    rd_reg(4'h2, 2'd3);
    cyc(1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 2'd3, 32'd0);
    idle(4'h2, 3);
    for (int a = 0; a < 4; a++) rd_reg(4'h2, 2'(a));

    // Randomized traffic.
    pin = 4'h2;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) pin = pin ^ 4'($urandom);
      if (r == 0) begin
        cyc(1'b1, pin, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), $urandom);
      end else begin
        cyc(1'b0, pin, 1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            2'($urandom), $urandom);
      end
    end
    idle(pin, 2);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
